approx_adder_error_checker: RTL and testbench
=============================================

Name: approx_adder_error_checker

Overview:
- Sequential initiator/checker that drives an approximate adder netlist (combinational, IN_W inputs, OUT_W outputs) through every input vector.
- Computes the exact sum internally, compares it against the netlist output and reports max absolute error, error count, pass/fail against ET and the first violating vector.
- Sits beside a generated approximate adder in the on-chip/FPGA validation wrapper; the adder is the responder, this block is the stimulus/monitor end.

Parameters:
- IN_W, 4, total adder inputs; two operands of IN_W/2 bits each; must be even, 2..16.
- OUT_W, 3, adder output width; must equal IN_W/2+1.
- ET, 1, error threshold; pass requires every |approx-exact| <= ET.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- clear  input  1  synchronous; returns to IDLE and zeroes all results.
- dut_in  output  IN_W  stimulus to adder: bit i drives in_i.
- dut_out  input  OUT_W  adder response: bit j is out_j.
- busy  output  1  high in DRIVE/SAMPLE.
- done  output  1  level, high in DONE.
- pass  output  1  max_err <= ET; valid while done.
- max_err  output  OUT_W  largest absolute error seen.
- err_count  output  IN_W+1  number of vectors with nonzero error.
- fail_valid  output  1  at least one vector had error > ET.
- fail_vec  output  IN_W  first vector (lowest index) with error > ET.

Behaviour:
- Reset (async assert, sync deassert at the wrapper): state IDLE, dut_in=0, busy=0, done=0, pass=0, max_err=0, err_count=0, fail_valid=0, fail_vec=0.
- Operand mapping: a = dut_in[IN_W/2-1:0], b = dut_in[IN_W-1:IN_W/2]; exact = a+b, OUT_W bits, unsigned, no overflow.
- Error: err = |dut_out - exact|, computed in OUT_W+1 bits and saturated to OUT_W bits (cannot exceed 2^OUT_W-1).
- FSM:
  - IDLE -> DRIVE on start. Load vec=0 and zero all results.
  - DRIVE: dut_in = vec, held one settle cycle -> SAMPLE.
  - SAMPLE: dut_in still = vec; register err. Update max_err = max(max_err, err); increment err_count if err != 0. If err > ET and fail_valid=0, set fail_valid=1 and fail_vec=vec.
  - SAMPLE exit: if vec = 2^IN_W-1 -> DONE, else vec+1 -> DRIVE.
  - DONE: done=1, results frozen, dut_in holds its last vector. start -> DRIVE with a fresh sweep (results zeroed).
- Timing: 2 cycles per vector. With start sampled at edge 0, done rises at edge 2*2^IN_W+1, which is 33 for IN_W=4.
- pass is combinational from max_err and ET; gated to 0 unless done=1.
- start while busy: ignored.
- clear beats start when both are high; clear mid-sweep aborts the sweep, and dut_in returns to 0 next cycle.
- Reset mid-sweep: immediate return to reset values.
- vec counter: IN_W bits; the terminal vector is detected explicitly, so no wrap occurs within a sweep.

Optional Feature:
- Macro: APPROX_CHK_SUM_ERR_EN.
- Defined: adds output sum_abs_err [OUT_W+IN_W-1:0], the accumulated err over all vectors. Zeroed on reset, clear and start; updated in SAMPLE; frozen in DONE.
- Undefined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Shared package approx_chk_pkg holds:
  - state enum {IDLE, DRIVE, SAMPLE, DONE};
  - function exact_sum(vec) implementing the operand mapping;
  - function abs_diff_sat.
- One natural sub-module, approx_err_accum: registers max_err, err_count, fail_* and the optional sum. Its inputs are sample_en, clr, err, vec.
- The FSM and vector counter stay in the top.

Test Plan:
- DUT = exact adder model -> done at edge 33; pass=1, max_err=0, err_count=0, fail_valid=0 (sum_abs_err=0).
- DUT = exact sum with out0 forced 0 -> max_err=1, err_count=8, pass=1, fail_valid=0 (sum_abs_err=8).
- DUT = exact sum with out2 stuck-at-0 -> max_err=4, err_count=6, pass=0, fail_valid=1, fail_vec=4'h7 (sum_abs_err=24).
- clear asserted at edge 10 mid-sweep -> next cycle IDLE, busy=0, all results 0, dut_in=0. A new start then completes normally in 33 cycles.
- start held high for the whole sweep plus extra pulses while busy -> exactly one sweep. After done, one more start re-runs from vec=0 with results zeroed.
- rst_n pulsed low asynchronously between edges mid-SAMPLE -> outputs reach reset values before the next edge; no result update from the interrupted vector.

Source files
------------

// File: rtl/approx_chk_pkg.sv
// approx_chk_pkg: shared FSM states and exact-sum/error helpers for the approximate adder checker
package approx_chk_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;
  localparam int MAX_W = 17;
  function automatic logic [MAX_W-1:0] exact_sum(input logic [MAX_W-1:0] vec, input int half);
    logic [MAX_W-1:0] m;
    m = (MAX_W'(1) << half) - MAX_W'(1);
    return (vec & m) + ((vec >> half) & m);
  endfunction
  function automatic logic [MAX_W-1:0] abs_diff_sat(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y, input int w);
    logic [MAX_W-1:0] d, lim;
    d = (x > y) ? x - y : y - x;
    lim = (MAX_W'(1) << w) - MAX_W'(1);
    return (d > lim) ? lim : d;
  endfunction
endpackage

// File: rtl/approx_err_accum.sv
// approx_err_accum: accumulates max error, error count, first failing vector (and sum_abs_err under APPROX_CHK_SUM_ERR_EN)
module approx_err_accum
  import approx_chk_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int OUT_W = 3,
  parameter int ET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              clr,
  input  logic [OUT_W-1:0]  err,
  input  logic [IN_W-1:0]   vec,
  output logic [OUT_W-1:0]  max_err,
  output logic [IN_W:0]     err_count,
  output logic              fail_valid,
  output logic [IN_W-1:0]   fail_vec
`ifdef APPROX_CHK_SUM_ERR_EN
  ,
  output logic [OUT_W+IN_W-1:0] sum_abs_err
`endif
);
  localparam logic [OUT_W:0] ET_V = (OUT_W+1)'(ET);
  logic [OUT_W-1:0] max_err_q, max_err_d;
  logic [IN_W:0] err_count_q, err_count_d;
  logic fail_valid_q, fail_valid_d, hit;
  logic [IN_W-1:0] fail_vec_q, fail_vec_d;
`ifdef APPROX_CHK_SUM_ERR_EN
  logic [OUT_W+IN_W-1:0] sum_q, sum_d;
  assign sum_abs_err = sum_q;
  always_comb sum_d = clr ? '0 : sample_en ? sum_q + (OUT_W+IN_W)'(err) : sum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
`endif
  always_comb begin
    hit = sample_en && ({1'b0, err} > ET_V) && !fail_valid_q;
    max_err_d = clr ? '0 : (sample_en && err > max_err_q) ? err : max_err_q;
    err_count_d = clr ? '0 : err_count_q + (IN_W+1)'(sample_en && err != '0);
    fail_valid_d = clr ? 1'b0 : fail_valid_q | hit;
    fail_vec_d = clr ? '0 : hit ? vec : fail_vec_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_err_q <= '0;
      err_count_q <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      max_err_q <= max_err_d;
      err_count_q <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q <= fail_vec_d;
    end
  assign max_err = max_err_q;
  assign err_count = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec = fail_vec_q;
endmodule

// File: rtl/approx_adder_error_checker.sv
// approx_adder_error_checker: sweeps every adder input vector, scores |approx-exact| vs ET (APPROX_CHK_SUM_ERR_EN adds sum_abs_err)
module approx_adder_error_checker
  import approx_chk_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int OUT_W = 3,
  parameter int ET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [OUT_W-1:0]  max_err,
  output logic [IN_W:0]     err_count,
  output logic              fail_valid,
  output logic [IN_W-1:0]   fail_vec
`ifdef APPROX_CHK_SUM_ERR_EN
  ,
  output logic [OUT_W+IN_W-1:0] sum_abs_err
`endif
);
  localparam logic [OUT_W:0] ET_V = (OUT_W+1)'(ET);
  state_e state_q, state_d;
  logic [IN_W-1:0] vec_q, vec_d, svec_q, svec_d;
  logic [OUT_W-1:0] err_q, err_d;
  logic sample_q, sample_d, clr, unused_hi;
  logic [MAX_W-1:0] exact_w, err_w;
  always_comb begin
    exact_w = exact_sum(MAX_W'(vec_q), IN_W/2);
    err_w = abs_diff_sat(MAX_W'(dut_out), MAX_W'(exact_w[OUT_W-1:0]), OUT_W);
    err_d = err_w[OUT_W-1:0];
    svec_d = vec_q;
    sample_d = (state_q == SAMPLE) && !clear;
    state_d = state_q;
    vec_d = vec_q;
    clr = clear;
    if (clear) begin
      state_d = IDLE;
      vec_d = '0;
    end else case (state_q)
      DRIVE: state_d = SAMPLE;
      SAMPLE: begin
        state_d = (vec_q == '1) ? DONE : DRIVE;
        vec_d = (vec_q == '1) ? vec_q : vec_q + IN_W'(1);
      end
      default: if (start) begin
        state_d = DRIVE;
        vec_d = '0;
        clr = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q <= '0;
      svec_q <= '0;
      err_q <= '0;
      sample_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      svec_q <= svec_d;
      err_q <= err_d;
      sample_q <= sample_d;
    end
  assign unused_hi = ^{exact_w[MAX_W-1:OUT_W], err_w[MAX_W-1:OUT_W]};
  assign dut_in = vec_q;
  assign busy = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done = (state_q == DONE) && !sample_q;
  assign pass = done && ({1'b0, max_err} <= ET_V);
  approx_err_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) u_accum (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_q),
    .clr(clr),
    .err(err_q),
    .vec(svec_q),
    .max_err(max_err),
    .err_count(err_count),
    .fail_valid(fail_valid),
    .fail_vec(fail_vec)
`ifdef APPROX_CHK_SUM_ERR_EN
    ,
    .sum_abs_err(sum_abs_err)
`endif
  );
endmodule

// File: tb/tb_approx_adder_error_checker.sv
// tb_approx_adder_error_checker: directed and random-LUT sweeps checked against a whole-sweep arithmetic model
module tb_approx_adder_error_checker;
  localparam int NV = 16;
  localparam int ET = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic [3:0] dut_in;
  logic [2:0] dut_out;
  logic busy, done, pass, fail_valid;
  logic [2:0] max_err;
  logic [4:0] err_count;
  logic [3:0] fail_vec;
`ifdef APPROX_CHK_SUM_ERR_EN
  logic [6:0] sum_abs_err;
`endif
  int checks = 0;
  int failures = 0;
  int mode = 0;
  logic [2:0] lut [NV];
  int x_max, x_cnt, x_fv, x_fvec, x_sum;
  always #5 clk = ~clk;
  function automatic int fixed(input int m, input int v);
    int e;
    e = (v % 4) + (v / 4);
    return (m == 1) ? (e & 6) : (m == 2) ? (e & 3) : e;
  endfunction
  always_comb dut_out = (mode == 3) ? lut[dut_in] : 3'(fixed(mode, int'(dut_in)));
  approx_adder_error_checker #(.IN_W(4), .OUT_W(3), .ET(ET)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .clear(clear),
    .dut_in(dut_in),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .max_err(max_err),
    .err_count(err_count),
    .fail_valid(fail_valid),
    .fail_vec(fail_vec)
`ifdef APPROX_CHK_SUM_ERR_EN
    ,
    .sum_abs_err(sum_abs_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model();
    int ap, ex, e;
    x_max = 0; x_cnt = 0; x_fv = 0; x_fvec = 0; x_sum = 0;
    for (int v = 0; v < NV; v++) begin
      ap = (mode == 3) ? int'(lut[v]) : fixed(mode, v);
      ex = (v % 4) + (v / 4);
      e = (ap > ex) ? ap - ex : ex - ap;
      if (e > x_max) x_max = e;
      if (e != 0) x_cnt++;
      x_sum += e;
      if (e > ET && x_fv == 0) begin
        x_fv = 1;
        x_fvec = v;
      end
    end
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_max_err"}, max_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_fail_valid"}, fail_valid, 0);
    chk({tag, "_fail_vec"}, fail_vec, 0);
`ifdef APPROX_CHK_SUM_ERR_EN
    chk({tag, "_sum"}, sum_abs_err, 0);
`endif
  endtask
  task automatic sweep(input int hold);
    int ed;
    model();
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_busy", busy, 1);
    chk("start_vec0", dut_in, 0);
    chk("start_max_err_zeroed", max_err, 0);
    chk("start_err_count_zeroed", err_count, 0);
    ed = -1;
    for (int n = 1; n <= 100 && ed < 0; n++) begin
      start = (n < hold);
      @(posedge clk); #1;
      if (done) ed = n;
    end
    start = 1'b0;
    chk("done_edge", ed, 33);
    chk("pass", pass, (x_max <= ET) ? 1 : 0);
    chk("max_err", max_err, x_max);
    chk("err_count", err_count, x_cnt);
    chk("fail_valid", fail_valid, x_fv);
    chk("fail_vec", fail_vec, x_fvec);
    chk("done_busy", busy, 0);
    chk("done_dut_in", dut_in, 15);
`ifdef APPROX_CHK_SUM_ERR_EN
    chk("sum_abs_err", sum_abs_err, x_sum);
`endif
    @(posedge clk); #1;
    chk("done_held", done, 1);
    chk("frozen_err_count", err_count, x_cnt);
  endtask
  initial begin
    @(posedge clk); #1;
    zero_chk("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 0; sweep(0);
    mode = 1; sweep(0);
    mode = 2; sweep(0);
    chk("stuck_fail_vec_7", fail_vec, 7);
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_clear_busy", busy, 1);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    zero_chk("clear");
    @(posedge clk); #1;
    chk("clear_stays_idle", busy, 0);
    sweep(0);
    mode = 2; sweep(31);
    mode = 1; sweep(0);
    mode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    zero_chk("async_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    zero_chk("post_reset");
    mode = 3;
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < NV; v++) lut[v] = 3'($urandom_range(0, 7));
      sweep(int'($urandom_range(0, 20)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
